lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_extend.sv | 27 ++
 rtl/lsu.sv | 143 ++++++++++++++
 tb/tb_lsu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: bus direction, enables, access sizes,
// FSM states, and helpers that derive byte enables and lane-replicated store data.
package lsu_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic ENABLE    = 1'b1;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    function automatic logic lsu_legal(input logic [2:0] funct3, input logic [1:0] off);
        logic ok;
        case (funct3)
            LSU_B, LSU_BU: ok = 1'b1;
            LSU_H, LSU_HU: ok = ~off[0];
            LSU_W:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Loads use the same enables as a store of the same size.
    function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] wd;
        case (funct3[1:0])
            2'b00:   wd = {4{wdata[7:0]}};
            2'b01:   wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Selects the addressed byte/half of a bus word and sign- or zero-extends it.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension according to the access size.
    always_comb begin
        byte_s = word_i[{offset_i, 3'b000} +: 8];
        half_s = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            LSU_B:   data_o = {{24{byte_s[7]}}, byte_s};
            LSU_BU:  data_o = {24'd0, byte_s};
            LSU_H:   data_o = {{16{half_s[15]}}, half_s};
            LSU_HU:  data_o = {16'd0, half_s};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes one request from EX, runs an ack-based bus transfer with a
// timeout, and returns extended load data with a one-cycle completion pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_ena,
    input  logic        ex_mem_rw,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        mem_rw_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done,
    output logic        fault,
    output logic        stall
);

    localparam logic [7:0] TMO_C = 8'(TIMEOUT);

    lsu_state_e  state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        rw_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic        mem_rw_q;
    logic [31:0] mem_rdata_q;
    logic        mem_done_q;
    logic        fault_q;
    logic        req_s;
    logic        legal_s;
    logic [31:0] load_data_s;

    lsu_extend u_extend (
        .word_i   (bus_rdata),
        .offset_i (off_q),
        .funct3_i (funct3_q),
        .data_o   (load_data_s)
    );

    assign req_s   = ex_valid && (ex_mem_ena == ENABLE);
    assign legal_s = lsu_legal(ex_funct3, ex_addr[1:0]);
    assign cnt_d   = cnt_q + 8'd1;

    // Gated by reset so the stall to cpu_ctrl drops the moment reset asserts.
    assign stall = rst && (((state_q == ST_IDLE) && req_s && legal_s) || (state_q == ST_BUSY));

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign mem_rw_o    = mem_rw_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done    = mem_done_q;
    assign fault       = fault_q;

    // Transfer FSM with all bus and writeback outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            rw_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            mem_rw_q    <= 1'b0;
            mem_rdata_q <= 32'd0;
            mem_done_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            mem_done_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_s && legal_s) begin
                        rw_q        <= ex_mem_rw;
                        funct3_q    <= ex_funct3;
                        off_q       <= ex_addr[1:0];
                        cnt_q       <= 8'd0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= (ex_mem_rw == MEM_WRITE);
                        bus_addr_q  <= {ex_addr[31:2], 2'b00};
                        bus_be_q    <= lsu_be(ex_funct3, ex_addr[1:0]);
                        bus_wdata_q <= lsu_wdata(ex_funct3, ex_wdata);
                        state_q     <= ST_BUSY;
                    end else if (req_s) begin
                        fault_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        bus_req_q   <= 1'b0;
                        mem_rw_q    <= rw_q;
                        mem_rdata_q <= (rw_q == MEM_WRITE) ? 32'd0 : load_data_s;
                        mem_done_q  <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (cnt_d == TMO_C) begin
                        bus_req_q   <= 1'b0;
                        mem_rw_q    <= rw_q;
                        mem_rdata_q <= 32'd0;
                        mem_done_q  <= 1'b1;
                        fault_q     <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    // EX still shows the finished instruction here, so it is not re-accepted.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan scenarios plus randomized accesses
// checked against a size/offset arithmetic model of the load/store rules.
module tb_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_ena = 1'b0;
    logic        ex_mem_rw = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        mem_rw_o, mem_done, fault, stall;
    logic [31:0] mem_rdata_o;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_ena(ex_mem_ena),
        .ex_mem_rw(ex_mem_rw), .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .mem_rw_o(mem_rw_o), .mem_rdata_o(mem_rdata_o), .mem_done(mem_done),
        .fault(fault), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        return (addr % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = m_size(f3);
        int mask = (1 << n) - 1;
        return 4'((mask << (addr % 4)) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = m_size(f3);
        if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        int n = m_size(f3);
        logic [31:0] v;
        logic [31:0] mask;
        v = word >> (8 * (addr % 4));
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (f3[2] == 1'b0 && ((v >> (8 * n - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        return v;
    endfunction

    // One access from EX presentation through DONE; waits = ack wait states.
    task automatic run_access(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] word,
                              input int waits, input bit no_ack);
        bit legal;
        logic [31:0] exp_data;
        int cyc;
        bit acked;
        legal = m_legal(f3, addr);
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_ena = 1'b1; ex_mem_rw = rw;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
        #1;
        checks++;
        if (stall !== legal) begin
            errors++;
            $display("FAIL accept_stall f3=%0d addr=%h: got %b exp %b", f3, addr, stall, legal);
        end
        if (!legal) begin
            @(negedge clk);
            ex_valid = 1'b0;
            #1;
            checks++;
            if ({fault, bus_req, stall, mem_done} !== 4'b1000) begin
                errors++;
                $display("FAIL illegal_fault f3=%0d addr=%h: got {fault,req,stall,done}=%b exp 1000",
                         f3, addr, {fault, bus_req, stall, mem_done});
            end
            @(negedge clk);
            checks++;
            if (fault !== 1'b0) begin
                errors++;
                $display("FAIL fault_pulse_width: got %b exp 0", fault);
            end
            return;
        end
        cyc = 0;
        acked = 1'b0;
        @(negedge clk);
        while (1) begin
            checks++;
            if ({bus_req, stall, bus_we, bus_addr, bus_be, bus_wdata} !==
                {1'b1, 1'b1, rw, addr & 32'hFFFF_FFFC, m_be(f3, addr), m_wdata(f3, wd)}) begin
                errors++;
                $display("FAIL busy_bus cyc=%0d: got req=%b stall=%b we=%b addr=%h be=%b wd=%h exp req=1 stall=1 we=%b addr=%h be=%b wd=%h",
                         cyc, bus_req, stall, bus_we, bus_addr, bus_be, bus_wdata,
                         rw, addr & 32'hFFFF_FFFC, m_be(f3, addr), m_wdata(f3, wd));
            end
            if (!no_ack && cyc == waits) begin
                bus_ack = 1'b1;
                bus_rdata = word;
                acked = 1'b1;
            end else begin
                bus_rdata = $urandom;
            end
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (acked || cyc + 1 == TMO) break;
            cyc++;
            @(negedge clk);
        end
        exp_data = (no_ack || rw) ? 32'd0 : m_load(f3, addr, word);
        @(negedge clk);
        checks++;
        if ({mem_done, fault, bus_req, stall, mem_rw_o, mem_rdata_o} !==
            {1'b1, no_ack, 1'b0, 1'b0, rw, exp_data}) begin
            errors++;
            $display("FAIL done f3=%0d addr=%h: got done=%b fault=%b req=%b stall=%b rw=%b data=%h exp done=1 fault=%b req=0 stall=0 rw=%b data=%h",
                     f3, addr, mem_done, fault, bus_req, stall, mem_rw_o, mem_rdata_o,
                     no_ack, rw, exp_data);
        end
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_done, fault, mem_rdata_o} !== {1'b0, 1'b0, exp_data}) begin
            errors++;
            $display("FAIL after_done: got done=%b fault=%b data=%h exp done=0 fault=0 data=%h",
                     mem_done, fault, mem_rdata_o, exp_data);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, mem_rw_o, mem_rdata_o, mem_done, fault, stall} !== 106'd0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs req=%b done=%b fault=%b stall=%b exp all 0",
                     bus_req, mem_done, fault, stall);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_lw;
        run_access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    endtask

    task automatic test_lb_lbu;
        run_access(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 0, 1'b0);
        run_access(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 1, 1'b0);
    endtask

    task automatic test_sh;
        run_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 2, 1'b0);
    endtask

    task automatic test_misaligned;
        run_access(1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 0, 1'b0);
        run_access(1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 0, 1'b0);
        run_access(1'b0, 3'b010, 32'h104, 32'd0, 32'h0BAD_F00D, 0, 1'b0);
    endtask

    task automatic test_timeout;
        run_access(1'b0, 3'b010, 32'h400, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
    endtask

    task automatic test_ignored_inputs;
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_ena = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h500;
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL disabled_stall: got %b exp 0", stall);
        end
        @(negedge clk);
        checks++;
        if ({bus_req, mem_done, fault} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ack_ignored: got {req,done,fault}=%b exp 000", {bus_req, mem_done, fault});
        end
        ex_valid = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_ena = 1'b1; ex_mem_rw = 1'b0;
        ex_funct3 = 3'b010; ex_addr = 32'h300;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: got req=%b exp 1", bus_req);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus_req, stall, mem_done, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_drop: got {req,stall,done,fault}=%b exp 0000",
                     {bus_req, stall, mem_done, fault});
        end
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_access(1'b0, 3'b010, 32'h300, 32'd0, 32'hCAFE_0123, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_access(1'b1, 3'b010, 32'h600, 32'hA5A5_5A5A, 32'd0, 0, 1'b0);
        run_access(1'b0, 3'b101, 32'h602, 32'd0, 32'h9876_5432, 0, 1'b0);
        run_access(1'b0, 3'b001, 32'h602, 32'd0, 32'h9876_5432, 3, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f3;
            logic [31:0] a;
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & ~(32'(m_size(f3)) - 32'd1);
            run_access(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
                       $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_lb_lbu;
        test_sh;
        test_misaligned;
        test_timeout;
        test_ignored_inputs;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
